jtvigil_vtgen: RTL

// - Parametrised video timing generator: pixel clock-enable divider, H/V counters, blanking, sync.
// - Runtime selects between two frame heights (55 Hz / 60 Hz); the change applies only at frame start.
// - Provides blanking outputs delayed by a parametrised number of pixels.
// - Sits at the top of the video path. Drives the tilemap/scroll fetch logic and the colour mixer.

---
 rtl/jtvigil_video_pkg.sv | 27 ++
 rtl/jtvigil_vtgen_dly.sv | 41 ++++
 rtl/jtvigil_vtgen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/jtvigil_video_pkg.sv
// Default Vigilante video timing constants and the frame-mode type.
// Shared by the timing generator and anything that needs its limits.
package jtvigil_video_pkg;

  localparam int VIGIL_CENDIV   = 8;
  localparam int VIGIL_HW       = 9;
  localparam int VIGIL_VW       = 9;
  localparam int VIGIL_H_LAST   = 383;
  localparam int VIGIL_HB_START = 255;
  localparam int VIGIL_HB_END   = 383;
  localparam int VIGIL_HS_START = 304;
  localparam int VIGIL_HS_END   = 336;
  localparam int VIGIL_V_LAST   = 279;
  localparam int VIGIL_V_LAST1  = 262;
  localparam int VIGIL_VB_START = 255;
  localparam int VIGIL_VB_END   = 279;
  localparam int VIGIL_VS_START = 260;
  localparam int VIGIL_VS_LEN   = 3;
  localparam int VIGIL_BLK_DLY  = 2;

  // MODE55 uses the taller frame (V_LAST), MODE60 the shorter one (V_LAST1).
  typedef enum logic {
    MODE55 = 1'b0,
    MODE60 = 1'b1
  } mode_t;

endpackage

// File: rtl/jtvigil_vtgen_dly.sv
// Clock-enabled shift register used to delay blanking signals by whole pixels.
// Ports:
//   clk   in  master clock
//   rst_n in  asynchronous active-low reset, presets every stage to 1
//   cen   in  shift enable (pixel clock enable)
//   din   in  signal to delay
//   dout  out din delayed by DEPTH enabled cycles (din itself when DEPTH=0)
module jtvigil_vtgen_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic din,
  output logic dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      // No delay requested: clock, reset and enable are not needed.
      logic unused;
      assign unused = clk ^ rst_n ^ cen;
      assign dout   = din;
    end else begin : g_sr
      logic [DEPTH-1:0] sr;

      // Blanking is inactive-high, so presetting to 1 keeps the delayed
      // copies inactive until real data has shifted through.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr <= '1;
        end else if (cen) begin
          sr <= DEPTH'({sr, din});
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/jtvigil_vtgen.sv
// Video timing generator: pixel clock-enable divider, H/V counters,
// blanking, sync and delayed blanking, with a runtime 55/60 Hz frame select.
// Ports:
//   clk       in  master clock
//   rst_n     in  asynchronous active-low reset
//   mode      in  frame height select, taken at frame start only
//   pxl_cen   out one clk pulse every CENDIV clks
//   pxl2_cen  out one clk pulse every CENDIV/2 clks
//   H         out horizontal count
//   vdump     out line being displayed
//   vrender   out next line (vdump+1, wrapping after the active last line)
//   Hinit     out high while H==H_LAST
//   Vinit     out high while H==H_LAST on the last line of the frame
//   LHBL/LVBL out horizontal/vertical blank, active low
//   HS/VS     out horizontal/vertical sync, active high
//   LHBL_dly  out LHBL delayed BLK_DLY pixels
//   LVBL_dly  out LVBL delayed BLK_DLY pixels
//   field     out toggles at every frame start
module jtvigil_vtgen
  import jtvigil_video_pkg::*;
#(
  parameter int CENDIV   = VIGIL_CENDIV,
  parameter int HW       = VIGIL_HW,
  parameter int VW       = VIGIL_VW,
  parameter int H_LAST   = VIGIL_H_LAST,
  parameter int HB_START = VIGIL_HB_START,
  parameter int HB_END   = VIGIL_HB_END,
  parameter int HS_START = VIGIL_HS_START,
  parameter int HS_END   = VIGIL_HS_END,
  parameter int V_LAST   = VIGIL_V_LAST,
  parameter int V_LAST1  = VIGIL_V_LAST1,
  parameter int VB_START = VIGIL_VB_START,
  parameter int VB_END   = VIGIL_VB_END,
  parameter int VS_START = VIGIL_VS_START,
  parameter int VS_LEN   = VIGIL_VS_LEN,
  parameter int BLK_DLY  = VIGIL_BLK_DLY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode,
  output logic          pxl_cen,
  output logic          pxl2_cen,
  output logic [HW-1:0] H,
  output logic [VW-1:0] vdump,
  output logic [VW-1:0] vrender,
  output logic          Hinit,
  output logic          Vinit,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS,
  output logic          LHBL_dly,
  output logic          LVBL_dly,
  output logic          field
);

  localparam int CW       = $clog2(CENDIV);
  localparam int VS_END_I = VS_START + VS_LEN;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CENDIV - 1);
  localparam logic [CW-1:0] HALF_MASK = CW'(CENDIV / 2 - 1);

  localparam logic [HW-1:0] H_LAST_C   = HW'(H_LAST);
  localparam logic [HW-1:0] H_PRE_C    = HW'(H_LAST - 1);
  localparam logic [HW-1:0] HB_START_C = HW'(HB_START);
  localparam logic [HW-1:0] HB_END_C   = HW'(HB_END);
  localparam logic [HW-1:0] HS_START_C = HW'(HS_START);
  localparam logic [HW-1:0] HS_END_C   = HW'(HS_END);

  localparam logic [VW-1:0] V_LAST_C   = VW'(V_LAST);
  localparam logic [VW-1:0] V_LAST1_C  = VW'(V_LAST1);
  localparam logic [VW-1:0] VB_START_C = VW'(VB_START);
  localparam logic [VW-1:0] VB_END_C   = VW'(VB_END);
  localparam logic [VW-1:0] VS_START_C = VW'(VS_START);

  // Parameter sanity checks, reported at elaboration.
  generate
    if (CENDIV < 2 || (CENDIV & (CENDIV - 1)) != 0) begin : g_bad_cendiv
      $error("jtvigil_vtgen: CENDIV must be a power of two >= 2");
    end
    if (H_LAST < 1 || H_LAST >= (1 << HW) || HB_START >= (1 << HW) ||
        HB_END >= (1 << HW) || HS_START >= (1 << HW) || HS_END >= (1 << HW)) begin : g_bad_h
      $error("jtvigil_vtgen: horizontal parameter does not fit in HW bits");
    end
    if (V_LAST >= (1 << VW) || V_LAST1 >= (1 << VW) || VB_START >= (1 << VW) ||
        VB_END >= (1 << VW) || VS_START >= (1 << VW) || VS_END_I >= (1 << VW)) begin : g_bad_v
      $error("jtvigil_vtgen: vertical parameter does not fit in VW bits");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  mode_t         act_mode;
  logic [VW-1:0] act_last;
  logic [VW-1:0] vb_end_eff;
  logic [VW-1:0] vs_clr;
  logic [VW-1:0] v_nxt;

  // The enables are registered from the next count so that they are high
  // exactly while cnt sits at its terminal value.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pxl_cen  <= 1'b0;
      pxl2_cen <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      pxl_cen  <= (cnt_nxt == CNT_LAST);
      pxl2_cen <= ((cnt_nxt & HALF_MASK) == HALF_MASK);
    end
  end

  // Frame-dependent limits. If the sync end line lies past the end of the
  // shorter frame, it wraps into the next frame so the pulse keeps its
  // length instead of sticking high.
  always_comb begin
    act_last   = (act_mode == MODE60) ? V_LAST1_C : V_LAST_C;
    vb_end_eff = (VB_END_C < act_last) ? VB_END_C : act_last;
    if (VS_END_I > int'(act_last)) begin
      vs_clr = VW'(VS_END_I - int'(act_last) - 1);
    end else begin
      vs_clr = VW'(VS_END_I);
    end
    v_nxt = (vdump == act_last) ? '0 : vdump + VW'(1);
  end

  // Timing state. Within each pair the set is written last so that it
  // wins when a set and a clear land on the same count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      H        <= '0;
      vdump    <= '0;
      vrender  <= VW'(1);
      Hinit    <= 1'b0;
      Vinit    <= 1'b0;
      LHBL     <= 1'b1;
      LVBL     <= 1'b1;
      HS       <= 1'b0;
      VS       <= 1'b0;
      act_mode <= MODE55;
      field    <= 1'b0;
    end else if (pxl_cen) begin
      H     <= (H == H_LAST_C) ? '0 : H + HW'(1);
      Hinit <= (H == H_PRE_C);
      Vinit <= (H == H_PRE_C) && (vdump == act_last);

      if (H == HB_START_C) LHBL <= 1'b0;
      if (H == HB_END_C)   LHBL <= 1'b1;
      if (H == HS_END_C)   HS   <= 1'b0;
      if (H == HS_START_C) HS   <= 1'b1;

      if (H == H_LAST_C) begin
        vdump   <= v_nxt;
        vrender <= (v_nxt == act_last) ? '0 : v_nxt + VW'(1);
        if (v_nxt == VB_START_C) LVBL <= 1'b0;
        if (v_nxt == vb_end_eff) LVBL <= 1'b1;
      end

      if (H == HS_START_C) begin
        if (vdump == vs_clr)     VS <= 1'b0;
        if (vdump == VS_START_C) VS <= 1'b1;
      end

      // Vinit is high on the wrap pixel, so the new mode only ever affects
      // the frame that is just starting.
      if (Vinit) begin
        act_mode <= mode ? MODE60 : MODE55;
        field    <= ~field;
      end
    end
  end

  jtvigil_vtgen_dly #(.DEPTH(BLK_DLY)) u_hbl_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (pxl_cen),
    .din  (LHBL),
    .dout (LHBL_dly)
  );

  jtvigil_vtgen_dly #(.DEPTH(BLK_DLY)) u_vbl_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .cen  (pxl_cen),
    .din  (LVBL),
    .dout (LVBL_dly)
  );

endmodule
